// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports, write-to-read bypass,
// a per-register busy scoreboard and a sequential bulk-clear engine.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_idx,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_idx,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     busy_set_en,
   input  logic [ADDR_W-1:0]        busy_set_idx,
   input  logic                     clr_start,
   output logic                     clr_busy,
   output logic                     clr_done
);
   localparam int NREGS = 1 << ADDR_W;
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
   state_t              state_q, state_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   regs_d [NREGS];
   logic [NREGS-1:0]    busy_q, busy_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                clearing, wr0_ok, wr1_ok, set_ok;
   assign clearing = state_q == CLEAR;
   assign wr0_ok   = wr0_en && !clearing && !(ZERO_REG != 0 && wr0_idx == '0);
   assign wr1_ok   = wr1_en && !clearing && !(ZERO_REG != 0 && wr1_idx == '0);
   assign set_ok   = busy_set_en && !clearing && !(ZERO_REG != 0 && busy_set_idx == '0);
   assign clr_busy = clearing;
   assign clr_done = state_q == DONE;
   always_comb begin
      regs_d  = regs_q;
      busy_d  = busy_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clearing) begin
         regs_d[cnt_q] = '0;
         busy_d[cnt_q] = 1'b0;
         cnt_d         = cnt_q + 1'b1;
         if (cnt_q == ADDR_W'(NREGS - 1)) state_d = DONE;
      end else begin
         if (wr0_ok) regs_d[wr0_idx] = wr0_data;
         // wr1 applied after wr0 so it wins on a shared index; set after clear so set wins
         if (wr1_ok) begin
            regs_d[wr1_idx] = wr1_data;
            busy_d[wr1_idx] = 1'b0;
         end
         if (set_ok) busy_d[busy_set_idx] = 1'b1;
         if (state_q == DONE) state_d = IDLE;
         else if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q  <= '{default: '0};
         busy_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic              hit0, hit1;
      assign idx  = rd_idx[g*ADDR_W +: ADDR_W];
      assign hit1 = BYPASS != 0 && wr1_ok && wr1_idx == idx;
      assign hit0 = BYPASS != 0 && wr0_ok && wr0_idx == idx;
      assign rd_data[g*DATA_W +: DATA_W] = (ZERO_REG != 0 && idx == '0) ? '0 :
                                           hit1 ? wr1_data : hit0 ? wr0_data : regs_q[idx];
      assign rd_busy[g] = busy_q[idx] && !hit1;
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed scoreboard bench; stimulus queues expectations, a negedge monitor checks them.
module tb_reg_file_mp;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  rd_idx = '0;
   logic [63:0] rd_data, z_rd_data;
   logic [1:0]  rd_busy, z_rd_busy;
   logic        wr0_en = 1'b0, wr1_en = 1'b0, busy_set_en = 1'b0, clr_start = 1'b0;
   logic [4:0]  wr0_idx = '0, wr1_idx = '0, busy_set_idx = '0;
   logic [31:0] wr0_data = '0, wr1_data = '0;
   logic        clr_busy, clr_done, z_clr_busy, z_clr_done;
   int          cyc = 0, checks = 0, errors = 0;
   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      logic [63:0] nm;
   } exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   reg_file_mp dut (
      .clk(clk), .rst(rst_n), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
      .busy_set_en(busy_set_en), .busy_set_idx(busy_set_idx),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
   );
   reg_file_mp #(.ZERO_REG(0)) dut_z (
      .clk(clk), .rst(rst_n), .rd_idx(rd_idx), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
      .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
      .busy_set_en(busy_set_en), .busy_set_idx(busy_set_idx),
      .clr_start(clr_start), .clr_busy(z_clr_busy), .clr_done(z_clr_done)
   );
   function automatic logic [31:0] sel(input int k);
      case (k)
         0:       return rd_data[31:0];
         1:       return rd_data[63:32];
         2:       return {31'b0, rd_busy[0]};
         3:       return {31'b0, clr_busy};
         4:       return {31'b0, clr_done};
         default: return z_rd_data[31:0];
      endcase
   endfunction
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] got;
         e = q.pop_front();
         got = sel(e.kind);
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL %0s cyc=%0d got=%h exp=%h", e.nm, e.cyc, got, e.val);
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
      wr0_en = 1'b0;
      wr1_en = 1'b0;
      busy_set_en = 1'b0;
      clr_start = 1'b0;
   endtask
   task automatic chk(input int k, input logic [31:0] v, input logic [63:0] nm);
      q.push_back('{cyc, k, v, nm});
   endtask
   task automatic rd(input int a, input int b);
      rd_idx = {5'(b), 5'(a)};
   endtask
   task automatic wr0(input int i, input logic [31:0] d);
      wr0_en = 1'b1; wr0_idx = 5'(i); wr0_data = d;
   endtask
   task automatic wr1(input int i, input logic [31:0] d);
      wr1_en = 1'b1; wr1_idx = 5'(i); wr1_data = d;
   endtask
   task automatic bset(input int i);
      busy_set_en = 1'b1; busy_set_idx = 5'(i);
   endtask
   task automatic run_clear();
      for (int k = 1; k <= 33; k++) begin
         step();
         chk(3, 32'(k <= 32), "clrbusy");
         chk(4, 32'(k == 33), "clrdone");
      end
   endtask
   initial begin
      step();
      rd(5, 10);
      chk(0, 0, "rst_rd0"); chk(1, 0, "rst_rd1"); chk(2, 0, "rst_busy");
      chk(3, 0, "rst_cbsy"); chk(4, 0, "rst_cdn");
      step();
      rst_n = 1'b1;
      // basic write, same-cycle bypass then array read
      step(); wr0(5, 32'h42); rd(5, 0); chk(0, 32'h42, "byp_wr0");
      step(); chk(0, 32'h42, "t1_rd");
      step(); wr0(10, 32'h1111); wr1(10, 32'h12345678); rd(10, 5);
      chk(0, 32'h12345678, "byp_wr1"); chk(1, 32'h42, "t2_p1");
      step(); chk(0, 32'h12345678, "t2_arr");
      step(); wr0(3, 32'hAAAA); wr1(4, 32'hBBBB); rd(3, 4);
      chk(0, 32'hAAAA, "byp_w0b"); chk(1, 32'hBBBB, "byp_w1b");
      step(); chk(0, 32'hAAAA, "arr3"); chk(1, 32'hBBBB, "arr4");
      // zero register, with and without hardwiring
      step(); wr1(0, 32'hFFFFFFFF); rd(0, 0);
      chk(0, 0, "zr_byp"); chk(5, 32'hFFFFFFFF, "nz_byp");
      step(); chk(0, 0, "zr_arr"); chk(5, 32'hFFFFFFFF, "nz_arr");
      // scoreboard
      step(); bset(7); rd(7, 0); chk(2, 0, "bs_pre");
      step(); chk(2, 1, "bs_set");
      step(); wr1(7, 32'h77); chk(2, 0, "bs_fwd"); chk(0, 32'h77, "bs_dat");
      step(); chk(2, 0, "bs_clr");
      step(); bset(7); wr1(7, 32'h78); chk(2, 0, "bs_both");
      step(); chk(2, 1, "bs_win"); chk(0, 32'h78, "bs_d78");
      step(); wr0(7, 32'h79); chk(2, 1, "bs_w0"); chk(0, 32'h79, "bs_d79");
      step(); chk(2, 1, "bs_w0b");
      step(); bset(0); rd(0, 0);
      step(); chk(2, 0, "bs_zero");
      // fill, then bulk clear
      for (int i = 1; i < 32; i++) begin
         step(); wr0(i, 32'h01010101 * i); rd(i, 0); chk(0, 32'h01010101 * i, "fill");
      end
      step(); clr_start = 1'b1; rd(7, 2);
      chk(3, 0, "c_idle"); chk(0, 32'h07070707, "c_pre7");
      for (int k = 1; k <= 33; k++) begin
         step();
         if (k == 10) begin
            wr0(2, 32'hDEAD); chk(1, 0, "c_nobyp");
         end
         if (k == 15) clr_start = 1'b1;
         if (k == 20) bset(3);
         if (k == 33) begin
            clr_start = 1'b1; wr0(9, 32'h99);
         end
         chk(3, 32'(k <= 32), "clrbusy");
         chk(4, 32'(k == 33), "clrdone");
      end
      step(); chk(3, 0, "c_ignst"); chk(4, 0, "c_dn1");
      for (int i = 0; i < 32; i++) begin
         step(); rd(i, 31 - i);
         chk(0, (i == 9) ? 32'h99 : 32'h0, "c_rd0");
         chk(1, (31 - i == 9) ? 32'h99 : 32'h0, "c_rd1");
         chk(2, 0, "c_busy");
      end
      // reset in the middle of a clear
      step(); wr0(12, 32'hC); wr1(20, 32'h14);
      step(); clr_start = 1'b1; rd(20, 12);
      for (int k = 1; k <= 12; k++) begin
         step(); chk(3, 1, "r_cbsy");
         if (k == 12) begin
            chk(0, 32'h14, "r_pre20"); chk(1, 32'hC, "r_pre12");
         end
      end
      step(); rst_n = 1'b0;
      chk(3, 0, "r_cb0"); chk(4, 0, "r_cd0"); chk(0, 0, "r_rd20"); chk(1, 0, "r_rd12");
      step(); rst_n = 1'b1; chk(3, 0, "r_idle");
      step(); chk(3, 0, "r_idle2"); chk(0, 0, "r_z20");
      step(); clr_start = 1'b1;
      run_clear();
      step(); chk(3, 0, "r_end");
      step(); step(); step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
